// File: rtl/lsu_pkg.sv
// Shared encodings for the load/store memory master: access sizes, FSM states,
// and the alignment rule applied when a request is accepted.
package lsu_pkg;

    localparam int LSU_DATA_W = 32;

    // Access size encodings as presented on req_size; 2'b11 behaves as a word.
    localparam logic [1:0] SZ_B = 2'b00;
    localparam logic [1:0] SZ_H = 2'b01;
    localparam logic [1:0] SZ_W = 2'b10;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_ERR     = 3'd1,
        ST_WR      = 3'd2,
        ST_RD      = 3'd3,
        ST_RD_DATA = 3'd4,
        ST_RMW_RD  = 3'd5,
        ST_RMW_WR  = 3'd6
    } lsu_state_e;

    // Halfwords need an even address and words a 4-byte aligned one; bytes are always fine.
    function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] addr_lo);
        logic mis;
        mis = 1'b0;
        if (size == SZ_H) begin
            mis = addr_lo[0];
        end else if (size[1]) begin
            mis = (addr_lo != 2'b00);
        end
        return mis;
    endfunction

endpackage

// File: rtl/lsu_mem_master_lane_align.sv
// Byte-lane steering between the 32-bit memory word and the CPU view:
// load extraction with sign/zero extension, and sub-word merge for read-modify-write.
module lsu_lane_align
    import lsu_pkg::*;
(
    input  logic [31:0] rdata,
    input  logic [31:0] wdata,
    input  logic [1:0]  addr_lo,
    input  logic [1:0]  size,
    input  logic        is_unsigned,
    output logic [31:0] load_data,
    output logic [31:0] merge_data
);

    logic [31:0] byte_shift;
    logic [31:0] half_shift;

    // Select the addressed lane(s) for loads and splice store data into the old word.
    always_comb begin
        byte_shift = rdata >> {addr_lo, 3'b000};
        half_shift = rdata >> {addr_lo[1], 4'b0000};
        load_data  = rdata;
        merge_data = rdata;
        case (size)
            SZ_B: begin
                load_data = {{24{~is_unsigned & byte_shift[7]}}, byte_shift[7:0]};
                merge_data[{addr_lo, 3'b000} +: 8] = wdata[7:0];
            end
            SZ_H: begin
                load_data = {{16{~is_unsigned & half_shift[15]}}, half_shift[15:0]};
                merge_data[{addr_lo[1], 4'b0000} +: 16] = wdata[15:0];
            end
            default: begin
                load_data  = rdata;
                merge_data = wdata;
            end
        endcase
    end

endmodule

// File: rtl/lsu_mem_master.sv
// Load/store initiator for a single-cycle-latency dual-port data memory.
// Handshake: a request transfers on a clock edge where req_valid && req_ready;
// req_ready is high only in IDLE, so at most one request is outstanding, and
// rsp_valid is a single-cycle pulse the consumer must take (no backpressure).
module lsu_mem_master
    import lsu_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_we,
    input  logic [1:0]            req_size,
    input  logic                  req_unsigned,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [DATA_WIDTH-1:0] req_wdata,
    output logic                  rsp_valid,
    output logic                  rsp_err,
    output logic [DATA_WIDTH-1:0] rsp_rdata,
    output logic                  mem_ren,
    output logic [ADDR_WIDTH-1:0] mem_raddr,
    input  logic [DATA_WIDTH-1:0] mem_rdata,
    output logic                  mem_wen,
    output logic [ADDR_WIDTH-1:0] mem_waddr,
    output logic [DATA_WIDTH-1:0] mem_wdata
);

    lsu_state_e            state_q, state_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [1:0]            size_q, size_d;
    logic                  we_q, we_d;
    logic                  uns_q, uns_d;
    logic [DATA_WIDTH-1:0] wdata_q, wdata_d;

    logic                  accept;
    logic [ADDR_WIDTH-1:0] word_index;
    logic [DATA_WIDTH-1:0] load_data;
    logic [DATA_WIDTH-1:0] merge_data;

    assign req_ready  = (state_q == ST_IDLE) && !rst;
    assign accept     = req_valid && req_ready;
    assign word_index = {2'b00, addr_q[ADDR_WIDTH-1:2]};
    assign mem_raddr  = word_index;
    assign mem_waddr  = word_index;

    lsu_lane_align u_align (
        .rdata       (mem_rdata),
        .wdata       (wdata_q),
        .addr_lo     (addr_q[1:0]),
        .size        (size_q),
        .is_unsigned (uns_q),
        .load_data   (load_data),
        .merge_data  (merge_data)
    );

    // Capture the request fields on acceptance; hold them for the whole transaction.
    always_comb begin
        addr_d  = addr_q;
        size_d  = size_q;
        we_d    = we_q;
        uns_d   = uns_q;
        wdata_d = wdata_q;
        if (accept) begin
            addr_d  = req_addr;
            size_d  = req_size;
            we_d    = req_we;
            uns_d   = req_unsigned;
            wdata_d = req_wdata;
        end
    end

    // Next-state and output decode; memory and response outputs depend only on state and latched regs.
    always_comb begin
        state_d   = state_q;
        rsp_valid = 1'b0;
        rsp_err   = 1'b0;
        rsp_rdata = '0;
        mem_ren   = 1'b0;
        mem_wen   = 1'b0;
        mem_wdata = '0;
        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    if (is_misaligned(req_size, req_addr[1:0])) begin
                        state_d = ST_ERR;
                    end else if (!req_we) begin
                        state_d = ST_RD;
                    end else if (req_size[1]) begin
                        state_d = ST_WR;
                    end else begin
                        state_d = ST_RMW_RD;
                    end
                end
            end
            ST_ERR: begin
                rsp_valid = 1'b1;
                rsp_err   = 1'b1;
                state_d   = ST_IDLE;
            end
            ST_WR: begin
                mem_wen   = 1'b1;
                mem_wdata = wdata_q;
                rsp_valid = 1'b1;
                state_d   = ST_IDLE;
            end
            ST_RD: begin
                mem_ren = 1'b1;
                state_d = ST_RD_DATA;
            end
            ST_RD_DATA: begin
                rsp_valid = 1'b1;
                rsp_rdata = load_data;
                state_d   = ST_IDLE;
            end
            ST_RMW_RD: begin
                mem_ren = 1'b1;
                state_d = ST_RMW_WR;
            end
            ST_RMW_WR: begin
                mem_wen   = 1'b1;
                mem_wdata = merge_data;
                rsp_valid = 1'b1;
                state_d   = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and request registers; reset abandons any transaction in flight.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            addr_q  <= '0;
            size_q  <= '0;
            we_q    <= 1'b0;
            uns_q   <= 1'b0;
            wdata_q <= '0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            size_q  <= size_d;
            we_q    <= we_d;
            uns_q   <= uns_d;
            wdata_q <= wdata_d;
        end
    end

endmodule
